// File: rtl/bottle_counter_fsm.sv
// Bottle tally responder for the line FSM's count/cont_done handshake.
// Keeps the BCD production total, box fill/total, discard count and overflow flag.
module bottle_counter_fsm #(
    parameter int unsigned BOX_SIZE = 12,
    parameter int unsigned BOX_TIME = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       count,
    input  logic       desc,
    input  logic       clr_cnt,
    output logic       cont_done,
    output logic       box_change,
    output logic [3:0] units,
    output logic [3:0] tens,
    output logic [7:0] box_fill,
    output logic [7:0] box_total,
    output logic [7:0] disc_cnt,
    output logic       ovf
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_INC    = 2'd1,
        S_BOXCHG = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t     state, state_next;
    logic [7:0] timer;
    logic       box_full;
    logic       do_inc;
    logic       do_clear;

    assign box_full = (box_fill == 8'(BOX_SIZE - 1));
    assign do_inc   = (state == S_INC);
    assign do_clear = (state == S_IDLE) && clr_cnt && !count;

    assign cont_done  = (state == S_DONE);
    assign box_change = (state == S_BOXCHG);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (count) state_next = S_INC;
            end
            S_INC: begin
                // A completed box always gets its full change time, even if the line stopped.
                if (box_full)   state_next = S_BOXCHG;
                else if (count) state_next = S_DONE;
                else            state_next = S_IDLE;
            end
            S_BOXCHG: begin
                if (timer == '0) state_next = count ? S_DONE : S_IDLE;
            end
            S_DONE: begin
                if (!count) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            units     <= '0;
            tens      <= '0;
            box_fill  <= '0;
            box_total <= '0;
            disc_cnt  <= '0;
            ovf       <= 1'b0;
            timer     <= '0;
        end else if (do_clear) begin
            units     <= '0;
            tens      <= '0;
            box_fill  <= '0;
            box_total <= '0;
            disc_cnt  <= '0;
            ovf       <= 1'b0;
        end else begin
            if (desc && (disc_cnt != '1)) begin
                disc_cnt <= disc_cnt + 8'd1;
            end

            if (do_inc) begin
                if (units == 4'd9) begin
                    units <= '0;
                    if (tens == 4'd9) begin
                        tens <= '0;
                        ovf  <= 1'b1;
                    end else begin
                        tens <= tens + 4'd1;
                    end
                end else begin
                    units <= units + 4'd1;
                end

                if (box_full) begin
                    box_fill  <= '0;
                    box_total <= box_total + 8'd1;
                    timer     <= 8'(BOX_TIME - 1);
                end else begin
                    box_fill <= box_fill + 8'd1;
                end
            end

            if ((state == S_BOXCHG) && (timer != '0)) begin
                timer <= timer - 8'd1;
            end
        end
    end

endmodule

// File: doc/bottle_counter_fsm.md
Name: bottle_counter_fsm

Overview:
- Responder for the count/cont_done handshake driven by the main line FSM in its counting state.
- Per accepted bottle: increments the BCD production total (00–99) and the bottles-in-current-box counter. When a box is full, it runs a timed box-change before acknowledging with cont_done.
- Also tallies discarded bottles from the main FSM's one-cycle discard strobe.
- Sits beside the main FSM; its BCD outputs feed the 7-segment display logic.

Parameters:
- BOX_SIZE, 12, bottles per box (2..255)
- BOX_TIME, 4, cycles box_change is held high (1..255)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- count  input  1  request level from main FSM; held high until cont_done seen, then dropped
- desc  input  1  discard strobe from main FSM, high one cycle per discarded bottle
- clr_cnt  input  1  synchronous clear of all tallies, honoured only in IDLE
- cont_done  output  1  acknowledge, high in DONE state
- box_change  output  1  high in BOXCHG state (box conveyor advance)
- units  output  4  BCD units of total bottles
- tens  output  4  BCD tens of total bottles
- box_fill  output  8  bottles in current box, 0..BOX_SIZE-1
- box_total  output  8  completed boxes, binary, wraps 255->0
- disc_cnt  output  8  discarded bottles, binary, saturates at 255
- ovf  output  1  sticky, set when total wraps 99->00

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All counters, ovf, cont_done and box_change are 0.
- All outputs are registered or decoded from state (Moore); no input reaches an output combinationally.
- IDLE:
  - cont_done=0, box_change=0.
  - count=1 -> INC.
  - clr_cnt=1 (and count=0) -> clears units, tens, box_fill, box_total, disc_cnt and ovf next edge.
  - count=1 and clr_cnt=1 together -> count wins, clr_cnt is ignored.
- INC (exactly 1 cycle; the increment is committed on leaving INC):
  - BCD increment: units 9->0 carries into tens; 99 -> 00 and sets ovf.
  - If box_fill+1 == BOX_SIZE: box_fill<=0, box_total++, timer<=BOX_TIME-1, -> BOXCHG.
  - Otherwise: box_fill++ and -> DONE.
  - If count already dropped (line stopped), the increment is still committed; next state is BOXCHG if the box completed, else IDLE.
- BOXCHG:
  - box_change=1.
  - Timer decrements each cycle; at timer==0 -> DONE if count=1, else IDLE.
  - box_change is therefore high exactly BOX_TIME cycles.
  - A count drop mid-change never truncates it.
- DONE:
  - cont_done=1; stays until count=0, then -> IDLE.
  - A new request requires count to be seen low for at least one cycle (four-phase handshake); no double counting while count stays high.
- Latency, count sampled high at edge n:
  - Counters update and cont_done rises at edge n+1 (no box).
  - With a box change: box_change is high edges n+1..n+BOX_TIME, and cont_done rises at edge n+1+BOX_TIME.
- desc:
  - Any cycle with desc=1 increments disc_cnt (saturating), in every state.
  - desc during clr_cnt: the clear wins.
- Illegal state encodings -> IDLE.

Test Plan:
- Reset low mid-BOXCHG -> all outputs 0 immediately, no clock needed; after release, state IDLE.
- count high at edge 1, dropped 1 cycle after cont_done -> units=1, tens=0, box_fill=1, cont_done high from edge 2 until count low; holding count high 10 extra cycles gives no further increment.
- 12 handshakes with BOX_SIZE=12, BOX_TIME=4 -> on 12th, box_change high exactly 4 cycles, then cont_done; box_fill=0, box_total=1, units=2, tens=1.
- 100 handshakes -> after 99th, tens=9/units=9; after 100th, 00 and ovf=1, ovf stays 1 until clr_cnt in IDLE.
- count dropped during INC of the 12th bottle -> box_change still 4 cycles, cont_done never asserted, return to IDLE, box_total=1.
- 300 desc pulses, including one during DONE -> disc_cnt=255 saturated; clr_cnt in IDLE -> all tallies 0; clr_cnt asserted in DONE -> ignored.
